// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell adds two WIDTH-bit operands LSB first.
// Latency: WIDTH cycles from the accepting start edge to the one-cycle done pulse.
// Backpressure: start is only sampled in IDLE or DONE; a start seen during RUN is dropped.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start, a, b, cin  request and operands, captured on an accepted start
//   busy            high while the serial add is running
//   done            one-cycle pulse, sum/cout valid
//   sum, cout       registered result, held until the next result
//   ovf             signed overflow; exists only when SERIAL_ADD_OVF_EN is defined
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic             carry;
  logic [CW-1:0]    cnt;
  // Only WIDTH-1 bits of partial sum are ever stored; the last bit goes
  // straight from the adder into the result register.
  logic [WIDTH-2:0] psum;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] psum_nx;

  // The shared 1-bit full-adder cell.
  always_comb begin
    fa_s    = sha[0] ^ shb[0] ^ carry;
    fa_co   = (sha[0] & shb[0]) | (carry & (sha[0] ^ shb[0]));
    psum_nx = {fa_s, psum};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sha   <= '0;
      shb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      psum  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sha   <= a;
            shb   <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          carry <= fa_co;
          sha   <= sha >> 1;
          shb   <= shb >> 1;
          psum  <= psum_nx[WIDTH-1:1];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Whole result lands in one edge so sum/cout are never seen half-built.
            sum   <= psum_nx;
            cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            // carry currently holds the carry into the MSB.
            ovf   <= carry ^ fa_co;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            sha   <= a;
            shb   <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
